// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg_if
//  Description : Receive-side holding-register bus between uart_rx_cfg and
//                its consumer (host/FIFO logic). The receiver offers a word
//                with rx_valid and the consumer takes it with rx_ready. Status
//                flags describe the word currently held. overrun is a
//                one-cycle event pulse.
//  Ports       : rx_data    - received word, zero-extended above frame length
//                rx_valid   - holding register full
//                rx_ready   - consumer accepts when rx_valid && rx_ready
//                parity_err - parity mismatch for the held word
//                frame_err  - a stop bit was sampled low for the held word
//                break_det  - held word was a break condition
//                overrun    - a frame was dropped because the register was full
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_cfg_if #(
   parameter int DATA_BITS_MAX = 8
);
   logic [DATA_BITS_MAX-1:0] rx_data;
   logic                     rx_valid;
   logic                     rx_ready;
   logic                     parity_err;
   logic                     frame_err;
   logic                     break_det;
   logic                     overrun;

   // Receiver side
   modport master (
      output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
      input  rx_ready
   );

   // Consumer side
   modport slave (
      input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
      output rx_ready
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Runtime-configurable oversampled UART receiver. Handles
//                5..DATA_BITS_MAX data bits, none/odd/even parity and one or
//                two stop bits. The line is double-flop synchronised, break
//                frames are flagged, and finished frames land in a one-entry
//                valid/ready holding register with overrun reporting.
//  Options     : UART_RX_MAJORITY_EN - when defined, each bit sample is the
//                2-of-3 majority of the synchronised line at the sample tick
//                and the two preceding oversample ticks. When undefined, a
//                single sample is taken at the sample tick.
//  Parameters  : DATA_BITS_MAX - rx_data width and longest frame (5..9)
//                OVS_FACTOR    - oversample ticks per bit (even, >= 8)
//  Ports       : clk        - system clock, rising edge
//                reset_n    - asynchronous active-low reset
//                tick_ovs   - single-cycle oversample strobe
//                rx_pin     - asynchronous serial input, idle high
//                cfg_len    - data bits per frame (out of range -> max)
//                cfg_parity - 00/11 none, 01 odd, 10 even
//                cfg_stop2  - 1 selects two stop bits
//                rx_bus     - holding-register bus (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
   parameter int DATA_BITS_MAX = 8,
   parameter int OVS_FACTOR    = 16
) (
   input  wire logic           clk,
   input  wire logic           reset_n,
   input  wire logic           tick_ovs,
   input  wire logic           rx_pin,
   input  wire logic [3:0]     cfg_len,
   input  wire logic [1:0]     cfg_parity,
   input  wire logic           cfg_stop2,
   uart_rx_cfg_if.master       rx_bus
);

   localparam int              CNT_W        = $clog2(OVS_FACTOR);
   localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(OVS_FACTOR/2 - 1);
   localparam logic [CNT_W-1:0] BIT_SAMPLE   = CNT_W'(OVS_FACTOR - 1);
   localparam logic [3:0]      LEN_MAX      = 4'(DATA_BITS_MAX);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_t;

   state_t                   state_q, state_d;
   logic                     sync1_q, sync2_q, rx_prev_q;
   logic [CNT_W-1:0]         os_cnt_q, os_cnt_d;
   logic [3:0]               bit_idx_q, bit_idx_d;
   logic [3:0]               len_q, len_d;
   logic                     par_en_q, par_en_d;
   logic                     par_odd_q, par_odd_d;
   logic                     stop2_q, stop2_d;
   logic [DATA_BITS_MAX-1:0] shift_q, shift_d;
   logic                     par_acc_q, par_acc_d;
   logic                     perr_q, perr_d;
   logic                     ferr_q, ferr_d;
   logic                     all_zero_q, all_zero_d;

   logic [DATA_BITS_MAX-1:0] rx_data_q, rx_data_d;
   logic                     rx_valid_q, rx_valid_d;
   logic                     parity_err_q, parity_err_d;
   logic                     frame_err_q, frame_err_d;
   logic                     break_det_q, break_det_d;
   logic                     overrun_q, overrun_d;

   logic                     rx_s;
   logic                     samp;
   logic                     bit_tick;
   logic                     frame_done;
   logic                     load;
   logic [3:0]               len_eff;

   assign rx_s     = sync2_q;
   assign bit_tick = tick_ovs && (os_cnt_q == BIT_SAMPLE);
   assign len_eff  = ((cfg_len < 4'd5) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] is rx_s at the previous tick, hist_q[1] the tick before that.
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (tick_ovs) begin
         hist_d = {hist_q[0], rx_s};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign samp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign samp = rx_s;
`endif

   // ------------------------------------------------------------------
   // Frame FSM: next state and per-frame datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      os_cnt_d   = os_cnt_q;
      bit_idx_d  = bit_idx_q;
      len_d      = len_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      stop2_d    = stop2_q;
      shift_d    = shift_q;
      par_acc_d  = par_acc_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      all_zero_d = all_zero_q;
      frame_done = 1'b0;

      // Bit-centre timing shared by every post-start state.
      if ((state_q == S_DATA) || (state_q == S_PARITY) ||
          (state_q == S_STOP1) || (state_q == S_STOP2)) begin
         if (tick_ovs) begin
            os_cnt_d = bit_tick ? '0 : os_cnt_q + 1'b1;
         end
         if (bit_tick && samp) begin
            all_zero_d = 1'b0;
         end
      end

      case (state_q)
         S_IDLE: begin
            os_cnt_d = '0;
            // Edge, not level: after a break the line must go high first.
            if (!rx_s && rx_prev_q) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (tick_ovs) begin
               if (os_cnt_q == START_SAMPLE) begin
                  os_cnt_d = '0;
                  if (!samp) begin
                     // Configuration is frozen here for the whole frame.
                     len_d      = len_eff;
                     par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                     par_odd_d  = (cfg_parity == 2'b01);
                     stop2_d    = cfg_stop2;
                     bit_idx_d  = '0;
                     shift_d    = '0;
                     par_acc_d  = 1'b0;
                     perr_d     = 1'b0;
                     ferr_d     = 1'b0;
                     all_zero_d = 1'b1;
                     state_d    = S_DATA;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         S_DATA: begin
            if (bit_tick) begin
               for (int i = 0; i < DATA_BITS_MAX; i++) begin
                  if (bit_idx_q == 4'(i)) begin
                     shift_d[i] = samp;
                  end
               end
               par_acc_d = par_acc_q ^ samp;
               if (bit_idx_q == (len_q - 4'd1)) begin
                  state_d = par_en_q ? S_PARITY : S_STOP1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end

         S_PARITY: begin
            if (bit_tick) begin
               // par_acc_q ^ samp is 1 when the total count of ones is odd.
               perr_d  = par_odd_q ? ~(par_acc_q ^ samp) : (par_acc_q ^ samp);
               state_d = S_STOP1;
            end
         end

         S_STOP1: begin
            if (bit_tick) begin
               if (!samp) begin
                  ferr_d = 1'b1;
               end
               if (stop2_q) begin
                  state_d = S_STOP2;
               end else begin
                  state_d    = S_IDLE;
                  frame_done = 1'b1;
               end
            end
         end

         S_STOP2: begin
            if (bit_tick) begin
               if (!samp) begin
                  ferr_d = 1'b1;
               end
               state_d    = S_IDLE;
               frame_done = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Holding register
   // ------------------------------------------------------------------
   // A load in the same cycle as an accept replaces the word without a gap.
   assign load = frame_done && (!rx_valid_q || rx_bus.rx_ready);

   always_comb begin
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      break_det_d  = break_det_q;
      overrun_d    = 1'b0;

      if (load) begin
         rx_data_d    = all_zero_d ? '0 : shift_q;
         parity_err_d = perr_q;
         frame_err_d  = ferr_d | all_zero_d;
         break_det_d  = all_zero_d;
         rx_valid_d   = 1'b1;
      end else if (frame_done) begin
         overrun_d = 1'b1;
      end else if (rx_valid_q && rx_bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= S_IDLE;
         os_cnt_q     <= '0;
         bit_idx_q    <= '0;
         len_q        <= LEN_MAX;
         par_en_q     <= 1'b0;
         par_odd_q    <= 1'b0;
         stop2_q      <= 1'b0;
         shift_q      <= '0;
         par_acc_q    <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         all_zero_q   <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         break_det_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= rx_pin;
         sync2_q      <= sync1_q;
         rx_prev_q    <= rx_s;
         state_q      <= state_d;
         os_cnt_q     <= os_cnt_d;
         bit_idx_q    <= bit_idx_d;
         len_q        <= len_d;
         par_en_q     <= par_en_d;
         par_odd_q    <= par_odd_d;
         stop2_q      <= stop2_d;
         shift_q      <= shift_d;
         par_acc_q    <= par_acc_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         all_zero_q   <= all_zero_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         break_det_q  <= break_det_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_bus.rx_data    = rx_data_q;
   assign rx_bus.rx_valid   = rx_valid_q;
   assign rx_bus.parity_err = parity_err_q;
   assign rx_bus.frame_err  = frame_err_q;
   assign rx_bus.break_det  = break_det_q;
   assign rx_bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Self-checking bench for uart_rx_cfg. Frames are serialised
//                onto rx_pin, expected words are queued as they are sent,
//                and a monitor collects every accepted word for comparison.
//                Build with UART_RX_MAJORITY_EN to add the glitch-vote test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

   localparam int DBM      = 8;
   localparam int OVS      = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLK  = OVS * TICK_DIV;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       tick_ovs   = 1'b0;
   logic       rx_pin     = 1'b1;
   logic [3:0] cfg_len    = 4'd8;
   logic [1:0] cfg_parity = 2'b00;
   logic       cfg_stop2  = 1'b0;

   uart_rx_cfg_if #(.DATA_BITS_MAX(DBM)) bus ();

   uart_rx_cfg #(
      .DATA_BITS_MAX (DBM),
      .OVS_FACTOR    (OVS)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_ovs   (tick_ovs),
      .rx_pin     (rx_pin),
      .cfg_len    (cfg_len),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .rx_bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DBM-1:0] data;
      logic           perr;
      logic           ferr;
      logic           brk;
   } frame_t;

   frame_t exp_q[$];
   frame_t got_q[$];
   int     vectors     = 0;
   int     miscompares = 0;
   int     ovr_cnt     = 0;
   int     ovr_run     = 0;
   int     ovr_max     = 0;

   // Oversample strobe: one clk high every TICK_DIV clks.
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         tick_ovs = (c == TICK_DIV - 1);
         c = (c + 1) % TICK_DIV;
      end
   end

   // Monitor: record every accepted word and measure overrun pulses.
   always @(negedge clk) begin
      if (reset_n && bus.rx_valid && bus.rx_ready) begin
         got_q.push_back({bus.rx_data, bus.parity_err, bus.frame_err, bus.break_det});
      end
      if (bus.overrun) begin
         ovr_cnt++;
         ovr_run++;
         if (ovr_run > ovr_max) ovr_max = ovr_run;
      end else begin
         ovr_run = 0;
      end
   end

   // ---------------- stimulus helpers and reference model ----------------
   task automatic line(input logic v, input int bits);
      rx_pin = v;
      repeat (bits * BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DBM-1:0] d, input int len,
                             input logic has_par, input logic pbit,
                             input logic s1, input logic two, input logic s2);
      line(1'b0, 1);
      for (int i = 0; i < len; i++) line(d[i], 1);
      if (has_par) line(pbit, 1);
      line(s1, 1);
      if (two) line(s2, 1);
   endtask

   function automatic logic par_model(input logic [DBM-1:0] d, input int len,
                                      input logic odd, input logic pbit);
      logic x;
      x = pbit;
      for (int i = 0; i < len; i++) x = x ^ d[i];
      return odd ? ~x : x;
   endfunction

   task automatic wait_got(input int budget);
      int n;
      n = 0;
      while (got_q.size() == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   // ------------------------------ tests ---------------------------------
   task automatic test_reset();
      logic [DBM+4:0] obs;
      reset_n = 1'b0;
      bus.rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      obs = {bus.rx_valid, bus.rx_data, bus.parity_err, bus.frame_err, bus.break_det, bus.overrun};
      vectors++;
      if (obs !== '0) begin
         $display("FAIL reset_outputs: got %h expected 0", obs);
         miscompares++;
      end
      reset_n = 1'b1;
      repeat (3 * BIT_CLK) @(negedge clk);
      vectors++;
      if (bus.rx_valid !== 1'b0 || got_q.size() != 0) begin
         $display("FAIL reset_no_false_start: valid %b frames %0d expected 0/0",
                  bus.rx_valid, got_q.size());
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      logic [DBM-1:0] pats [3] = '{8'hA5, 8'h00, 8'hFF};
      frame_t e, g;
      cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      foreach (pats[i]) begin
         exp_q.push_back('{data: pats[i], perr: 1'b0, ferr: 1'b0, brk: 1'b0});
         send_frame(pats[i], 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      line(1'b1, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_got(4 * BIT_CLK);
         vectors++;
         if (got_q.size() == 0) begin
            $display("FAIL b2b_frame: no frame, expected %h", e);
            miscompares++;
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               $display("FAIL b2b_frame: got %h expected %h", g, e);
               miscompares++;
            end
         end
      end
      vectors++;
      if (got_q.size() != 0) begin
         $display("FAIL b2b_extra: %0d extra frames expected 0", got_q.size());
         miscompares++;
         got_q.delete();
      end
   endtask

   task automatic test_len_cfg();
      frame_t e, g;
      // Out-of-range length falls back to the full 8 bits.
      cfg_len = 4'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      exp_q.push_back('{data: 8'h96, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      // 6-bit frame; configuration changed mid-frame must not matter.
      cfg_len = 4'd6;
      exp_q.push_back('{data: 8'h2B, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      fork
         send_frame(8'h2B, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         begin
            repeat (2 * BIT_CLK) @(negedge clk);
            cfg_len = 4'd8; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
         end
      join
      line(1'b1, 2);
      cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_got(4 * BIT_CLK);
         vectors++;
         if (got_q.size() == 0) begin
            $display("FAIL len_frame: no frame, expected %h", e);
            miscompares++;
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               $display("FAIL len_frame: got %h expected %h", g, e);
               miscompares++;
            end
         end
      end
   endtask

   task automatic test_parity();
      // {cfg_parity, parity bit sent}
      logic [2:0] cases [4] = '{3'b10_1, 3'b10_0, 3'b01_0, 3'b11_1};
      frame_t e, g;
      cfg_len = 4'd7; cfg_stop2 = 1'b0;
      foreach (cases[i]) begin
         logic has_par, odd, pbit;
         cfg_parity = cases[i][2:1];
         pbit       = cases[i][0];
         has_par    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
         odd        = (cfg_parity == 2'b01);
         exp_q.push_back('{data: 8'h41,
                           perr: has_par ? par_model(8'h41, 7, odd, pbit) : 1'b0,
                           ferr: 1'b0, brk: 1'b0});
         send_frame(8'h41, 7, has_par, pbit, 1'b1, 1'b0, 1'b1);
      end
      line(1'b1, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_got(4 * BIT_CLK);
         vectors++;
         if (got_q.size() == 0) begin
            $display("FAIL parity_frame: no frame, expected %h", e);
            miscompares++;
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               $display("FAIL parity_frame: got %h expected %h", g, e);
               miscompares++;
            end
         end
      end
      cfg_len = 4'd8; cfg_parity = 2'b00;
   endtask

   task automatic test_stop2();
      frame_t e, g;
      cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
      exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1, brk: 1'b0});
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      line(1'b1, 1);
      exp_q.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b1, brk: 1'b0});
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      line(1'b1, 1);
      exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      line(1'b1, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_got(4 * BIT_CLK);
         vectors++;
         if (got_q.size() == 0) begin
            $display("FAIL stop2_frame: no frame, expected %h", e);
            miscompares++;
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               $display("FAIL stop2_frame: got %h expected %h", g, e);
               miscompares++;
            end
         end
      end
      cfg_stop2 = 1'b0;
   endtask

   task automatic test_break();
      frame_t e, g;
      cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
      line(1'b0, 12);
      line(1'b1, 3);
      e = exp_q.pop_front();
      wait_got(BIT_CLK);
      vectors++;
      if (got_q.size() == 0) begin
         $display("FAIL break_frame: no frame, expected %h", e);
         miscompares++;
      end else begin
         g = got_q.pop_front();
         if (g !== e) begin
            $display("FAIL break_frame: got %h expected %h", g, e);
            miscompares++;
         end
      end
      vectors++;
      if (got_q.size() != 0) begin
         $display("FAIL break_single: %0d extra frames expected 0", got_q.size());
         miscompares++;
         got_q.delete();
      end
      // Normal reception resumes on the next falling edge.
      exp_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      line(1'b1, 1);
      e = exp_q.pop_front();
      wait_got(4 * BIT_CLK);
      vectors++;
      if (got_q.size() == 0) begin
         $display("FAIL break_recover: no frame, expected %h", e);
         miscompares++;
      end else begin
         g = got_q.pop_front();
         if (g !== e) begin
            $display("FAIL break_recover: got %h expected %h", g, e);
            miscompares++;
         end
      end
   endtask

   task automatic test_overrun();
      frame_t e, g;
      int     ovr_before;
      cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      @(posedge clk); #1;
      bus.rx_ready = 1'b0;
      ovr_before = ovr_cnt;
      ovr_max    = 0;
      exp_q.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      line(1'b1, 1);
      vectors++;
      if ((ovr_cnt - ovr_before) != 1 || ovr_max != 1) begin
         $display("FAIL overrun_pulse: pulses %0d width %0d expected 1/1",
                  ovr_cnt - ovr_before, ovr_max);
         miscompares++;
      end
      vectors++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
         $display("FAIL overrun_hold: valid %b data %h expected 1/11",
                  bus.rx_valid, bus.rx_data);
         miscompares++;
      end
      @(posedge clk); #1;
      bus.rx_ready = 1'b1;
      e = exp_q.pop_front();
      wait_got(8);
      vectors++;
      if (got_q.size() == 0) begin
         $display("FAIL overrun_accept: no frame, expected %h", e);
         miscompares++;
      end else begin
         g = got_q.pop_front();
         if (g !== e) begin
            $display("FAIL overrun_accept: got %h expected %h", g, e);
            miscompares++;
         end
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.rx_valid !== 1'b0 || got_q.size() != 0) begin
         $display("FAIL overrun_clear: valid %b extra %0d expected 0/0",
                  bus.rx_valid, got_q.size());
         miscompares++;
         got_q.delete();
      end
   endtask

   task automatic test_glitch();
      frame_t e, g;
      cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      rx_pin = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      line(1'b1, 2);
      vectors++;
      if (bus.rx_valid !== 1'b0 || got_q.size() != 0) begin
         $display("FAIL glitch_reject: valid %b frames %0d expected 0/0",
                  bus.rx_valid, got_q.size());
         miscompares++;
         got_q.delete();
      end
      exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      line(1'b1, 1);
      e = exp_q.pop_front();
      wait_got(4 * BIT_CLK);
      vectors++;
      if (got_q.size() == 0) begin
         $display("FAIL glitch_recover: no frame, expected %h", e);
         miscompares++;
      end else begin
         g = got_q.pop_front();
         if (g !== e) begin
            $display("FAIL glitch_recover: got %h expected %h", g, e);
            miscompares++;
         end
      end
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_majority();
      frame_t e, g;
      logic [DBM-1:0] d;
      d = 8'hF0;
      cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      exp_q.push_back('{data: d, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      line(1'b0, 1);
      // Bit 0 is a 0 with a one-tick-wide high pulse around its centre.
      rx_pin = 1'b0;
      repeat (BIT_CLK/2 - 2) @(negedge clk);
      rx_pin = 1'b1;
      repeat (TICK_DIV) @(negedge clk);
      rx_pin = 1'b0;
      repeat (BIT_CLK/2 - 2 - TICK_DIV + 4) @(negedge clk);
      for (int i = 1; i < 8; i++) line(d[i], 1);
      line(1'b1, 2);
      e = exp_q.pop_front();
      wait_got(4 * BIT_CLK);
      vectors++;
      if (got_q.size() == 0) begin
         $display("FAIL majority_vote: no frame, expected %h", e);
         miscompares++;
      end else begin
         g = got_q.pop_front();
         if (g !== e) begin
            $display("FAIL majority_vote: got %h expected %h", g, e);
            miscompares++;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_len_cfg();
      test_parity();
      test_stop2();
      test_break();
      test_overrun();
      test_glitch();
`ifdef UART_RX_MAJORITY_EN
      test_majority();
`endif
      vectors++;
      if (ovr_cnt != 1) begin
         $display("FAIL overrun_total: %0d pulses expected 1", ovr_cnt);
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
